// File: rtl/fft_if.sv
// fft_if: host-side bus of the FFT accelerator.
//   sig   start request (rising edge launches a transform while idle)
//   we    write enable for the sample buffer
//   rev   bit-reverse the buffer address before access
//   addr  word address; only the low LOGN bits select a word
//   din   complex sample {real, imag}, each DW bits
//   dout  registered read data, same packing as din
//   busy  high while a transform is running
interface fft_if #(
   parameter int DW = 64
);
   logic          sig;
   logic          we;
   logic          rev;
   logic [31:0]   addr;
   logic [2*DW-1:0] din;
   logic [2*DW-1:0] dout;
   logic          busy;

   modport master (output sig, we, rev, addr, din, input dout, busy);
   modport slave  (input sig, we, rev, addr, din, output dout, busy);
endinterface

// File: rtl/fft_core.sv
// fft_core: in-place radix-2 decimation-in-time FFT over an N = 2**LOGN point complex
// buffer. The host loads samples (normally with rev=1 so they land in bit-reversed
// order), raises sig, waits for busy to fall, then reads bins in natural order.
//   clk   rising-edge system clock
//   rst   asynchronous active-low reset (aborts a running transform)
//   bus   fft_if slave: sig/we/rev/addr/din in, dout/busy out
// Components are signed Q16.48 (DW bits); twiddles are signed Q2.30 (TW bits).
module fft_core #(
   parameter int LOGN = 12,
   parameter int DW   = 64,
   parameter int TW   = 32
) (
   input logic  clk,
   input logic  rst,
   fft_if.slave bus
);
   localparam int  N     = 2 ** LOGN;
   localparam int  RW    = $clog2(LOGN);
   localparam int  PW    = DW + TW + 1;
   localparam int  TOTAL = LOGN * (N / 2 + 3);
   localparam real PI    = 3.14159265358979323846;

   // Real value to signed TW-bit fixed point with TW-2 fraction bits, nearest.
   function automatic logic signed [TW-1:0] to_q(input real x);
      real s;
      s = x * (2.0 ** (TW - 2));
      return TW'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
   endfunction

   // Drop the twiddle fraction bits and wrap to the data width.
   function automatic logic signed [DW-1:0] scale(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] s;
      s = p >>> (TW - 2);
      return s[DW-1:0];
   endfunction

   function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
      for (int i = 0; i < LOGN; i++) bitrev[i] = x[LOGN-1-i];
   endfunction

   // Twiddle ROM: cos and -sin of 2*pi*k/N, fixed at elaboration.
   logic signed [TW-1:0] rom_c [N/2];
   logic signed [TW-1:0] rom_s [N/2];
   for (genvar i = 0; i < N / 2; i++) begin : g_rom
      localparam real ANG = 2.0 * PI * i / N;
      localparam logic signed [TW-1:0] WC = to_q($cos(ANG));
      localparam logic signed [TW-1:0] WS = to_q(-$sin(ANG));
      assign rom_c[i] = WC;
      assign rom_s[i] = WS;
   end

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t          state, state_nx;
   logic [RW-1:0]   rnd, rnd_nx;
   logic [LOGN-2:0] iter, iter_nx;
   logic [1:0]      dcnt, dcnt_nx;
   logic [31:0]     cycle, cycle_nx;
   logic            sig_q, issue, busy;

   assign busy     = (state != IDLE);
   assign bus.busy = busy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         rnd   <= '0;
         iter  <= '0;
         dcnt  <= '0;
         cycle <= '0;
         sig_q <= 1'b0;
      end else begin
         state <= state_nx;
         rnd   <= rnd_nx;
         iter  <= iter_nx;
         dcnt  <= dcnt_nx;
         cycle <= cycle_nx;
         sig_q <= bus.sig;
      end
   end

   // One butterfly issued per RUN cycle; DRAIN lets the last writes land before
   // the next stage reads. The final drain cycle is also the last counted cycle.
   always_comb begin
      state_nx = state;
      rnd_nx   = rnd;
      iter_nx  = iter;
      dcnt_nx  = dcnt;
      cycle_nx = cycle;
      issue    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.sig && !sig_q) begin
               state_nx = RUN;
               rnd_nx   = '0;
               iter_nx  = '0;
               cycle_nx = '0;
            end
         end
         RUN: begin
            issue    = 1'b1;
            cycle_nx = cycle + 1;
            iter_nx  = iter + 1'b1;
            if (iter == '1) begin
               state_nx = DRAIN;
               dcnt_nx  = '0;
            end
         end
         DRAIN: begin
            cycle_nx = cycle + 1;
            dcnt_nx  = dcnt + 2'd1;
            if (cycle == 32'(TOTAL - 1)) begin
               state_nx = IDLE;
            end else if (dcnt == 2'd2) begin
               state_nx = RUN;
               rnd_nx   = rnd + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Butterfly indices for the current issue slot.
   logic [LOGN-1:0] it, half, jj, ia, ib;
   logic [LOGN-2:0] kk;
   always_comb begin
      it   = {1'b0, iter};
      half = LOGN'(1) << rnd;
      jj   = it & (half - 1'b1);
      ia   = (((it >> rnd) << rnd) << 1) | jj;
      ib   = ia | half;
      kk   = jj[LOGN-2:0] << (LOGN - 1 - int'(rnd));
   end

   logic [LOGN-1:0] host_a;
   logic            unused_addr;
   assign host_a      = bus.rev ? bitrev(bus.addr[LOGN-1:0]) : bus.addr[LOGN-1:0];
   assign unused_addr = ^bus.addr[31:LOGN];

   logic [2*DW-1:0]      mem [N];
   logic [2*DW-1:0]      q_a, q_b, c_p2, d_p2, dout;
   logic signed [TW-1:0] wc_p1, ws_p1;
   logic [LOGN-1:0]      ia_p1, ib_p1, ia_p2, ib_p2;
   logic                 vld_p1, vld_p2;
   logic                 wa_en;
   logic [LOGN-1:0]      wa_addr;
   logic [2*DW-1:0]      wa_data;

   // Port A belongs to the host while idle and to write-back while busy.
   assign wa_en   = busy ? vld_p2 : bus.we;
   assign wa_addr = busy ? ia_p2  : host_a;
   assign wa_data = busy ? c_p2   : bus.din;

   // Buffer RAM: both butterfly legs read and both results written each clock.
   always_ff @(posedge clk) begin
      if (wa_en)  mem[wa_addr] <= wa_data;
      if (vld_p2) mem[ib_p2]   <= d_p2;
      q_a <= mem[ia];
      q_b <= mem[ib];
   end

   // Host read port: write-first, frozen while a transform runs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       dout <= '0;
      else if (!busy) dout <= bus.we ? bus.din : mem[host_a];
   end
   assign bus.dout = dout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= issue;
         vld_p2 <= vld_p1;
      end
   end

   // ---- p1: RAM operands (q_a/q_b) and twiddle available ----
   always_ff @(posedge clk) begin
      wc_p1 <= rom_c[kk];
      ws_p1 <= rom_s[kk];
      ia_p1 <= ia;
      ib_p1 <= ib;
   end

   logic signed [DW-1:0] ar, ai, br, bi, wbr, wbi;
   logic signed [PW-1:0] mr, mi;
   always_comb begin
      ar  = q_a[2*DW-1:DW];
      ai  = q_a[DW-1:0];
      br  = q_b[2*DW-1:DW];
      bi  = q_b[DW-1:0];
      mr  = PW'(br) * PW'(wc_p1) - PW'(bi) * PW'(ws_p1);
      mi  = PW'(br) * PW'(ws_p1) + PW'(bi) * PW'(wc_p1);
      wbr = scale(mr);
      wbi = scale(mi);
   end

   // ---- p2: butterfly results registered, written back next edge ----
   always_ff @(posedge clk) begin
      c_p2  <= {ar + wbr, ai + wbi};
      d_p2  <= {ar - wbr, ai - wbi};
      ia_p2 <= ia_p1;
      ib_p2 <= ib_p1;
   end
endmodule

// File: tb/tb_fft_core.sv
module tb_fft_core;
   localparam int     LOGN  = 4;
   localparam int     N     = 16;
   localparam int     DW    = 64;
   localparam int     TW    = 32;
   localparam int     TOTAL = LOGN * (N / 2 + 3);
   localparam longint ONE   = 64'sh0001_0000_0000_0000;
   localparam longint TOL   = 64'sd268435456;
   localparam real    PI    = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst = 1'b1;
   fft_if #(.DW(DW)) bus ();
   fft_core #(.LOGN(LOGN), .DW(DW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] want;
      longint       tol;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;
   logic rd_req = 1'b0;
   logic rd_vld = 1'b0;
   logic [127:0] xs [N];

   always @(posedge clk) rd_vld <= rd_req;

   function automatic logic [127:0] cplx(input longint re, input longint im);
      return {re, im};
   endfunction

   function automatic longint q48(input real r);
      return longint'(r * 281474976710656.0);
   endfunction

   task automatic cmp(input string name, input logic [127:0] got, input logic [127:0] want,
                      input longint tol);
      logic signed [64:0] dr, di;
      dr = 65'($signed(got[127:64])) - 65'($signed(want[127:64]));
      di = 65'($signed(got[63:0])) - 65'($signed(want[63:0]));
      if (dr < 0) dr = -dr;
      if (di < 0) di = -di;
      checks++;
      if (dr > 65'(tol) || di > 65'(tol)) begin
         errors++;
         $display("FAIL %s: got re=%h im=%h, required re=%h im=%h (+-%0d)", name,
                  got[127:64], got[63:0], want[127:64], want[63:0], tol);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   // Monitor: every registered read is compared with the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rd_vld) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: read data %h with no expectation", bus.dout);
         end else begin
            e = sb.pop_front();
            cmp(e.name, bus.dout, e.want, e.tol);
         end
      end
   end

   task automatic wr(input int idx, input logic [127:0] v);
      @(negedge clk);
      rd_req = 1'b0; bus.we = 1'b1; bus.rev = 1'b1; bus.addr = idx; bus.din = v;
   endtask

   task automatic rd(input logic [31:0] a, input logic rv, input logic [127:0] want,
                     input longint tol, input string name);
      @(negedge clk);
      bus.we = 1'b0; bus.rev = rv; bus.addr = a; rd_req = 1'b1;
      sb.push_back('{name, want, tol});
   endtask

   task automatic load_all();
      for (int n = 0; n < N; n++) wr(n, xs[n]);
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic run_fft(input bit disturb, input logic [127:0] hold);
      int n;
      @(negedge clk);
      bus.we = 1'b0; rd_req = 1'b0; bus.sig = 1'b1;
      @(posedge clk); #1;
      chk_int("busy_rise", int'(bus.busy), 1);
      n = 0;
      while (bus.busy && n < TOTAL + 20) begin
         @(posedge clk); #1;
         n++;
         if (n == 3) bus.sig = 1'b0;
         if (disturb && n == 10) begin
            bus.sig = 1'b1; bus.we = 1'b1; bus.rev = 1'b0; bus.addr = 0;
            bus.din = {2{64'h7777_0000_0000_0000}};
         end
         if (disturb && n == 12) begin
            bus.sig = 1'b0; bus.we = 1'b0;
         end
         if (disturb && n == 20) cmp("dout_hold_busy", bus.dout, hold, 0);
      end
      bus.sig = 1'b0; bus.we = 1'b0;
      chk_int("busy_cycles", n, TOTAL);
   endtask

   task automatic impulse0();
      for (int n = 0; n < N; n++) xs[n] = '0;
      xs[0] = cplx(ONE, 0);
   endtask

   task automatic read_flat(input string tag);
      for (int k = 0; k < N; k++) rd(k, 1'b0, cplx(ONE, 0), 0, $sformatf("%s_bin%0d", tag, k));
   endtask

   initial begin
      bus.sig = 1'b0; bus.we = 1'b0; bus.rev = 1'b0; bus.addr = '0; bus.din = '0;
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp("reset_dout", bus.dout, '0, 0);
      chk_int("reset_busy", int'(bus.busy), 0);
      @(negedge clk) rst = 1'b1;

      // Address bit reversal and ignored upper address bits.
      wr(1, 128'h1);
      rd(N / 2, 1'b0, 128'h1, 0, "bitrev_natural");
      rd(32'hABCD_0000 | (N / 2), 1'b0, 128'h1, 0, "upper_addr_ignored");
      rd(1, 1'b1, 128'h1, 0, "bitrev_reversed");

      // Impulse at x[0], with a retrigger pulse and a host write during the run.
      impulse0();
      load_all();
      rd(0, 1'b1, cplx(ONE, 0), 0, "pre_run_read");
      run_fft(1'b1, cplx(ONE, 0));
      read_flat("impulse");

      // DC input: all energy in bin 0.
      for (int n = 0; n < N; n++) xs[n] = cplx(ONE, 0);
      load_all();
      run_fft(1'b0, '0);
      rd(0, 1'b0, cplx(N * ONE, 0), 0, "dc_bin0");
      for (int k = 1; k < N; k++) rd(k, 1'b0, '0, TOL, $sformatf("dc_bin%0d", k));

      // Cosine at bin 1: half amplitude in bins 1 and N-1.
      for (int n = 0; n < N; n++) xs[n] = cplx(q48($cos(2.0 * PI * n / N)), 0);
      load_all();
      run_fft(1'b0, '0);
      for (int k = 0; k < N; k++)
         rd(k, 1'b0, (k == 1 || k == N - 1) ? cplx((N / 2) * ONE, 0) : '0, TOL,
            $sformatf("cos_bin%0d", k));

      // Impulse at x[1]: X[k] = cos(2pi k/N) - j sin(2pi k/N).
      for (int n = 0; n < N; n++) xs[n] = '0;
      xs[1] = cplx(ONE, 0);
      load_all();
      run_fft(1'b0, '0);
      for (int k = 0; k < N; k++)
         rd(k, 1'b0, cplx(q48($cos(2.0 * PI * k / N)), q48(-$sin(2.0 * PI * k / N))), TOL,
            $sformatf("shift_bin%0d", k));

      // Reset in the middle of stage 2, then a clean rerun.
      impulse0();
      load_all();
      rd(0, 1'b1, cplx(ONE, 0), 0, "pre_abort_read");
      @(negedge clk);
      rd_req = 1'b0; bus.sig = 1'b1;
      repeat (2 * (N / 2 + 3) + 5) @(posedge clk);
      #1;
      chk_int("abort_busy_before", int'(bus.busy), 1);
      cmp("abort_dout_before", bus.dout, cplx(ONE, 0), 0);
      bus.sig = 1'b0;
      rst = 1'b0;
      #1;
      chk_int("abort_busy", int'(bus.busy), 0);
      chk_int("abort_rnd", int'(dut.rnd), 0);
      cmp("abort_dout", bus.dout, '0, 0);
      @(negedge clk) rst = 1'b1;
      load_all();
      run_fft(1'b0, '0);
      read_flat("rerun");

      @(negedge clk);
      rd_req = 1'b0;
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
